// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the 3-sample majority vote used to decide each bit.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_e;

    localparam int         OVS_RATE      = 16;
    localparam logic [3:0] SAMPLE_MID_LO = 4'd7;
    localparam logic [3:0] SAMPLE_MID_HI = 4'd9;
    localparam logic [3:0] SAMPLE_LAST   = 4'(OVS_RATE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every OVS_DIV clks, restartable via clr_i.
module uart_baud_tick #(
    parameter int OVS_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVS_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 16x oversampled, majority-voted bits, optional parity, and a
// single-entry valid/ready output holding register with framing/overrun flags.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int OVS_DIV    = 27,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_e            state_q;
    logic                 rx_meta_q, rxs_q;
    logic [3:0]           s_q;
    logic [2:0]           bit_cnt_q;
    logic                 v_lo_q, v_mid_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 perr_q;
    logic [DATA_BITS-1:0] m_data_q;
    logic                 m_valid_q, frame_err_q, parity_err_q, overrun_q, busy_q;

    logic tick, clr_d, vote_d, mid_hi_d, bit_end_d, complete_d, accept_d, slot_free_d;

    // Divider restarts when a falling edge pulls us out of IDLE.
    assign clr_d = (state_q == IDLE) && !rxs_q;

    uart_baud_tick #(.OVS_DIV(OVS_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_d),
        .tick_o(tick)
    );

    assign vote_d      = majority3(v_lo_q, v_mid_q, rxs_q);
    assign mid_hi_d    = tick && (s_q == SAMPLE_MID_HI);
    assign bit_end_d   = tick && (s_q == SAMPLE_LAST);
    assign complete_d  = (state_q == STOP) && mid_hi_d;
    assign accept_d    = m_valid_q && m_ready;
    assign slot_free_d = !m_valid_q || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= IDLE;
            s_q          <= '0;
            bit_cnt_q    <= '0;
            v_lo_q       <= 1'b0;
            v_mid_q      <= 1'b0;
            shreg_q      <= '0;
            perr_q       <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;

            if (state_q != IDLE && tick) begin
                s_q <= s_q + 4'd1;
                if (s_q == SAMPLE_MID_LO)         v_lo_q  <= rxs_q;
                if (s_q == SAMPLE_MID_LO + 4'd1)  v_mid_q <= rxs_q;
            end

            case (state_q)
                IDLE: if (!rxs_q) begin
                    state_q   <= START;
                    busy_q    <= 1'b1;
                    s_q       <= '0;
                    bit_cnt_q <= '0;
                    perr_q    <= 1'b0;
                end
                START: begin
                    if (mid_hi_d && vote_d) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (bit_end_d) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (mid_hi_d) shreg_q <= {vote_d, shreg_q[DATA_BITS-1:1]};
                    if (bit_end_d) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (mid_hi_d) perr_q <= vote_d ^ (^shreg_q) ^ 1'(PARITY_ODD);
                    if (bit_end_d) state_q <= STOP;
                end
                STOP: if (mid_hi_d) begin
                    state_q <= vote_d ? IDLE : BREAK;
                    busy_q  <= !vote_d;
                end
                BREAK: if (rxs_q) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // A completing frame either refills the slot or is dropped as an overrun.
            if (complete_d) begin
                if (slot_free_d) begin
                    m_data_q     <= shreg_q;
                    m_valid_q    <= 1'b1;
                    frame_err_q  <= !vote_d;
                    parity_err_q <= perr_q;
                    overrun_q    <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept_d) begin
                m_valid_q <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus randomized frames on an
// 8N1 instance and an 8O1 instance, checked against frame-level expectations.
module tb_uart_rx_deserializer;

    logic       clk;
    logic       rst_n;
    logic       rx0, rx1;
    logic [7:0] m_data0, m_data1;
    logic       m_valid0, m_valid1;
    logic       m_ready0, m_ready1;
    logic       frame_err0, frame_err1;
    logic       parity_err0, parity_err1;
    logic       overrun0, overrun1;
    logic       busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount0  = 0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];

    uart_rx_deserializer #(.OVS_DIV(1), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(m_ready0), .frame_err(frame_err0), .parity_err(parity_err0),
        .overrun(overrun0), .busy(busy0)
    );

    uart_rx_deserializer #(.OVS_DIV(1), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .m_data(m_data1), .m_valid(m_valid1),
        .m_ready(m_ready1), .frame_err(frame_err1), .parity_err(parity_err1),
        .overrun(overrun1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake that will take place at the coming rising edge.
    always @(negedge clk) begin
        if (m_valid0) vcount0++;
        if (m_valid0 && m_ready0) q0.push_back('{d: m_data0, fe: frame_err0, pe: parity_err0});
        if (m_valid1 && m_ready1) q1.push_back('{d: m_data1, fe: frame_err1, pe: parity_err1});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) rx1 = v;
        else     rx0 = v;
        step(n);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                              input logic par, input logic stop, input int idle);
        drive(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive(sel, d[i], 16);
        if (use_par) drive(sel, par, 16);
        drive(sel, stop, 16);
        if (idle > 0) drive(sel, 1'b1, idle);
    endtask

    task automatic expect_frame(input bit sel, input string tag, input logic [7:0] d,
                                input logic fe, input logic pe);
        rec_t r;
        int   sz;
        sz = sel ? q1.size() : q0.size();
        chk({tag, "_count"}, sz, 1);
        if (sz > 0) begin
            r = sel ? q1.pop_front() : q0.pop_front();
            chk({tag, "_data"}, r.d, d);
            chk({tag, "_ferr"}, r.fe, fe);
            chk({tag, "_perr"}, r.pe, pe);
        end
        if (sel) q1.delete();
        else     q0.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       st, pb;
        int         vc;

        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; m_ready0 = 1'b1; m_ready1 = 1'b1;
        step(3);
        @(negedge clk);
        chk("rst_m_data",  m_data0, 0);
        chk("rst_m_valid", m_valid0, 0);
        chk("rst_ferr",    frame_err0, 0);
        chk("rst_perr",    parity_err0, 0);
        chk("rst_overrun", overrun0, 0);
        chk("rst_busy",    busy0, 0);
        rst_n = 1'b1;
        step(5);

        // Plain 8N1 byte with the consumer always ready.
        vc = vcount0;
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 20);
        @(negedge clk);
        expect_frame(0, "a5", 8'hA5, 1'b0, 1'b0);
        chk("a5_valid_cycles", vcount0 - vc, 1);
        chk("a5_valid_low",    m_valid0, 0);
        chk("a5_overrun",      overrun0, 0);
        chk("a5_busy",         busy0, 0);

        // Short low glitch must be rejected as a false start.
        vc = vcount0;
        drive(0, 1'b0, 4);
        rx0 = 1'b1;
        @(negedge clk);
        chk("glitch_busy_hi", busy0, 1);
        step(12);
        @(negedge clk);
        chk("glitch_busy_lo", busy0, 0);
        chk("glitch_no_valid", vcount0 - vc, 0);
        chk("glitch_no_frame", q0.size(), 0);

        // Missing stop bit with the line held low afterwards.
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 0);
        drive(0, 1'b0, 24);
        @(negedge clk);
        chk("brk_busy_hi", busy0, 1);
        expect_frame(0, "brk", 8'h3C, 1'b1, 1'b0);
        drive(0, 1'b0, 16);
        @(negedge clk);
        chk("brk_no_new_low", q0.size(), 0);
        drive(0, 1'b1, 20);
        @(negedge clk);
        chk("brk_busy_lo", busy0, 0);
        chk("brk_no_new_high", q0.size(), 0);

        // Reset in the middle of the data bits of 0x5A.
        d = 8'h5A;
        drive(0, 1'b0, 16);
        for (int i = 0; i < 3; i++) drive(0, d[i], 16);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_m_data",  m_data0, 0);
        chk("mrst_m_valid", m_valid0, 0);
        chk("mrst_ferr",    frame_err0, 0);
        chk("mrst_busy",    busy0, 0);
        chk("mrst_overrun", overrun0, 0);
        rx0 = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(10);
        chk("mrst_no_frame", q0.size(), 0);
        send_frame(0, 8'h96, 0, 1'b0, 1'b1, 20);
        @(negedge clk);
        expect_frame(0, "after_rst", 8'h96, 1'b0, 1'b0);

        // Two frames into a stalled consumer: second is dropped.
        m_ready0 = 1'b0;
        send_frame(0, 8'h11, 0, 1'b0, 1'b1, 4);
        send_frame(0, 8'h22, 0, 1'b0, 1'b1, 10);
        @(negedge clk);
        chk("ovr_valid",   m_valid0, 1);
        chk("ovr_data",    m_data0, 8'h11);
        chk("ovr_flag",    overrun0, 1);
        step(1);
        m_ready0 = 1'b1;
        step(1);
        @(negedge clk);
        chk("ovr_acc_valid", m_valid0, 0);
        chk("ovr_acc_flag",  overrun0, 0);
        expect_frame(0, "ovr_acc", 8'h11, 1'b0, 1'b0);

        // Odd parity: 0x07 has three ones, so the correct parity bit is 0.
        send_frame(1, 8'h07, 1, 1'b0, 1'b1, 20);
        @(negedge clk);
        expect_frame(1, "par_ok", 8'h07, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1, 1'b1, 1'b1, 20);
        @(negedge clk);
        expect_frame(1, "par_bad", 8'h07, 1'b0, 1'b1);

        // Randomized frames on both instances.
        for (int i = 0; i < 12; i++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            send_frame(0, d, 0, 1'b0, st, 20);
            @(negedge clk);
            expect_frame(0, "rnd_8n1", d, !st, 1'b0);
            chk("rnd_8n1_busy", busy0, 0);

            d  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            pb = 1'($urandom_range(0, 1));
            send_frame(1, d, 1, pb, st, 20);
            @(negedge clk);
            expect_frame(1, "rnd_8o1", d, !st, pb != ~(^d));
            chk("rnd_8o1_busy", busy1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
